// File: rtl/wavetable_read_arbiter_pkg.sv
// Shared types and default sizing for the wavetable ROM read arbiter.
package wavetable_read_arbiter_pkg;

  localparam int unsigned DefaultPipelineCount = 4;
  localparam int unsigned DefaultTableSelWidth = 2;
  localparam int unsigned DefaultAddrWidth     = 10;
  localparam int unsigned DefaultDataWidth     = 24;
  localparam int unsigned DefaultReadLatency   = 1;

  typedef struct packed {
    logic [DefaultTableSelWidth-1:0] table_sel;
    logic [DefaultAddrWidth-1:0]     addr;
  } wt_req_t;

  typedef logic [DefaultPipelineCount-1:0] owner_t;

endpackage

// File: rtl/wavetable_read_arbiter_if.sv
// Request/response and ROM-side signal bundle; slave is the arbiter, master is pipelines plus ROM.
interface wavetable_read_arbiter_if
  import wavetable_read_arbiter_pkg::*;
#(
  parameter int unsigned PIPELINE_COUNT  = DefaultPipelineCount,
  parameter int unsigned TABLE_SEL_WIDTH = DefaultTableSelWidth,
  parameter int unsigned ADDR_WIDTH      = DefaultAddrWidth,
  parameter int unsigned DATA_WIDTH      = DefaultDataWidth
);
  logic [PIPELINE_COUNT-1:0]                      req;
  logic [PIPELINE_COUNT-1:0][TABLE_SEL_WIDTH-1:0] req_table;
  logic [PIPELINE_COUNT-1:0][ADDR_WIDTH-1:0]      req_addr;
  logic [PIPELINE_COUNT-1:0]                      grant;
  logic [PIPELINE_COUNT-1:0]                      rsp_valid;
  logic [DATA_WIDTH-1:0]                          rsp_data;
  logic                                           mem_en;
  logic [TABLE_SEL_WIDTH-1:0]                     mem_table;
  logic [ADDR_WIDTH-1:0]                          mem_addr;
  logic [DATA_WIDTH-1:0]                          mem_rdata;
  logic [7:0]                                     max_wait;

  modport slave (
    input  req, req_table, req_addr, mem_rdata,
    output grant, rsp_valid, rsp_data, mem_en, mem_table, mem_addr, max_wait
  );

  modport master (
    output req, req_table, req_addr, mem_rdata,
    input  grant, rsp_valid, rsp_data, mem_en, mem_table, mem_addr, max_wait
  );
endinterface

// File: rtl/wavetable_read_arbiter_rr_picker.sv
// Combinational round-robin select: first requester at or after rr_ptr, wrapping.
module wavetable_read_arbiter_rr_picker #(
  parameter  int unsigned PIPELINE_COUNT = 4,
  localparam int unsigned PtrW           = $clog2(PIPELINE_COUNT)
) (
  input  logic [PIPELINE_COUNT-1:0] req,
  input  logic [PtrW-1:0]           rr_ptr,
  output logic [PIPELINE_COUNT-1:0] winner_oh,
  output logic [PtrW-1:0]           winner_idx,
  output logic                      any
);
  int unsigned idx;

  always_comb begin
    winner_oh  = '0;
    winner_idx = '0;
    any        = 1'b0;
    idx        = 0;
    for (int unsigned i = 0; i < PIPELINE_COUNT; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= PIPELINE_COUNT) idx = idx - PIPELINE_COUNT;
      if (!any && req[idx]) begin
        any            = 1'b1;
        winner_oh[idx] = 1'b1;
        winner_idx     = PtrW'(idx);
      end
    end
  end
endmodule

// File: rtl/wavetable_read_arbiter.sv
// Shares one synchronous wavetable ROM among several pipelines; returns each sample to its owner.
// Optional wait statistics are enabled by defining WT_ARB_STATS_EN.
module wavetable_read_arbiter
  import wavetable_read_arbiter_pkg::*;
#(
  parameter int unsigned PIPELINE_COUNT  = DefaultPipelineCount,
  parameter int unsigned TABLE_SEL_WIDTH = DefaultTableSelWidth,
  parameter int unsigned ADDR_WIDTH      = DefaultAddrWidth,
  parameter int unsigned DATA_WIDTH      = DefaultDataWidth,
  parameter int unsigned READ_LATENCY    = DefaultReadLatency
) (
  input logic                     clock_50_000_000,
  input logic                     reset_l,
  wavetable_read_arbiter_if.slave bus
);
  localparam int unsigned PtrW = $clog2(PIPELINE_COUNT);

  logic [PIPELINE_COUNT-1:0] pick_oh;
  logic [PtrW-1:0]           pick_idx;
  logic                      pick_any;
  logic [PtrW-1:0]           rr_ptr_q, rr_ptr_d;

  wavetable_read_arbiter_rr_picker #(
    .PIPELINE_COUNT(PIPELINE_COUNT)
  ) u_rr_picker (
    .req       (bus.req),
    .rr_ptr    (rr_ptr_q),
    .winner_oh (pick_oh),
    .winner_idx(pick_idx),
    .any       (pick_any)
  );

  assign bus.grant = pick_oh;

  logic                       mem_en_q;
  logic [TABLE_SEL_WIDTH-1:0] mem_table_q, mem_table_d;
  logic [ADDR_WIDTH-1:0]      mem_addr_q, mem_addr_d;

  // Owner tags ride alongside the read; slot READ_LATENCY lines up with mem_rdata.
  logic [READ_LATENCY:0][PIPELINE_COUNT-1:0] tag_q, tag_d;
  logic [PIPELINE_COUNT-1:0]                 rsp_valid_q;
  logic [DATA_WIDTH-1:0]                     rsp_data_q, rsp_data_d;

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    mem_table_d = mem_table_q;
    mem_addr_d  = mem_addr_q;
    if (pick_any) begin
      rr_ptr_d    = (pick_idx == PtrW'(PIPELINE_COUNT - 1)) ? '0 : pick_idx + 1'b1;
      mem_table_d = bus.req_table[pick_idx];
      mem_addr_d  = bus.req_addr[pick_idx];
    end
    tag_d      = {tag_q[READ_LATENCY-1:0], pick_oh};
    rsp_data_d = (|tag_q[READ_LATENCY]) ? bus.mem_rdata : rsp_data_q;
  end

  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      rr_ptr_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_table_q <= '0;
      mem_addr_q  <= '0;
      tag_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      mem_en_q    <= pick_any;
      mem_table_q <= mem_table_d;
      mem_addr_q  <= mem_addr_d;
      tag_q       <= tag_d;
      rsp_valid_q <= tag_q[READ_LATENCY];
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_table = mem_table_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

`ifdef WT_ARB_STATS_EN
  logic [PIPELINE_COUNT-1:0][7:0] wait_q, wait_d;
  logic [7:0]                     max_wait_q, max_wait_d;

  always_comb begin
    wait_d     = wait_q;
    max_wait_d = max_wait_q;
    for (int unsigned i = 0; i < PIPELINE_COUNT; i++) begin
      if (bus.req[i] && !pick_oh[i]) begin
        if (wait_q[i] != 8'hFF) wait_d[i] = wait_q[i] + 8'd1;
      end else begin
        wait_d[i] = '0;
      end
    end
    // Counter value sampled before it clears on this grant.
    if (pick_any && (wait_q[pick_idx] > max_wait_q)) max_wait_d = wait_q[pick_idx];
  end

  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      wait_q     <= '0;
      max_wait_q <= '0;
    end else begin
      wait_q     <= wait_d;
      max_wait_q <= max_wait_d;
    end
  end

  assign bus.max_wait = max_wait_q;
`else
  assign bus.max_wait = 8'd0;
`endif

endmodule

// File: tb/tb_wavetable_read_arbiter.sv
// Self-checking bench for wavetable_read_arbiter: directed scenarios plus a randomized run
// against a queue-based model of arbitration order and response timing.
module tb_wavetable_read_arbiter;
  import wavetable_read_arbiter_pkg::*;

  localparam int P = 4;
`ifdef WT_ARB_STATS_EN
  localparam logic [7:0] ExpMaxWait = 8'd3;
`else
  localparam logic [7:0] ExpMaxWait = 8'd0;
`endif

  logic clk = 1'b0;
  logic reset_l = 1'b0;
  always #5 clk = ~clk;

  wavetable_read_arbiter_if #(
    .PIPELINE_COUNT (P),
    .TABLE_SEL_WIDTH(2),
    .ADDR_WIDTH     (10),
    .DATA_WIDTH     (24)
  ) bus ();

  wavetable_read_arbiter #(
    .PIPELINE_COUNT (P),
    .TABLE_SEL_WIDTH(2),
    .ADDR_WIDTH     (10),
    .DATA_WIDTH     (24),
    .READ_LATENCY   (1)
  ) dut (
    .clock_50_000_000(clk),
    .reset_l         (reset_l),
    .bus             (bus)
  );

  int checks = 0;
  int failures = 0;

  // ROM model: one-cycle synchronous read, optionally forced to a fixed word.
  logic        rom_force = 1'b0;
  logic [23:0] rom_force_val = 24'd0;
  logic [23:0] rom_q = 24'd0;

  function automatic logic [23:0] rom_fn(logic [1:0] t, logic [9:0] a);
    return ({22'd0, t} * 24'h0F1E2D) ^ ({14'd0, a} * 24'h000A37) ^ 24'h3C3C3C;
  endfunction

  always @(posedge clk) if (bus.mem_en) rom_q <= rom_force ? rom_force_val : rom_fn(bus.mem_table, bus.mem_addr);
  assign bus.mem_rdata = rom_q;

  // Reference model: grant = first requester from ptr; response due 3 cycles after grant.
  typedef struct {
    int          due;
    owner_t      owner;
    logic [23:0] data;
  } exp_t;

  exp_t    exp_q[$];
  int      cyc = 0;
  int      m_ptr = 0;
  logic    m_en = 1'b0;
  wt_req_t m_issue = '0;

  function automatic owner_t model_pick(owner_t r, int ptr);
    for (int k = 0; k < P; k++) if (r[(ptr + k) % P]) return owner_t'(1) << ((ptr + k) % P);
    return '0;
  endfunction

  always @(posedge clk) begin
    owner_t g;
    if (reset_l) begin
      g = model_pick(bus.req, m_ptr);
      if (exp_q.size() > 0 && exp_q[0].due == cyc) void'(exp_q.pop_front());
      m_en = (g != '0);
      for (int k = 0; k < P; k++) begin
        if (g[k]) begin
          m_ptr   = (k + 1) % P;
          m_issue = '{table_sel: bus.req_table[k], addr: bus.req_addr[k]};
          exp_q.push_back('{due: cyc + 3, owner: g,
                            data: rom_force ? rom_force_val
                                            : rom_fn(bus.req_table[k], bus.req_addr[k])});
        end
      end
    end
    cyc++;
  end

  always @(negedge reset_l) begin
    exp_q.delete();
    m_ptr   = 0;
    m_en    = 1'b0;
    m_issue = '0;
  end

  task automatic apply_reset();
    @(negedge clk);
    bus.req = '0;
    reset_l = 1'b0;
    repeat (2) @(negedge clk);
    reset_l = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      checks++;
      if (bus.grant !== 4'b0 || bus.mem_en !== 1'b0 || bus.rsp_valid !== 4'b0) begin
        failures++;
        $display("FAIL reset_idle i=%0d grant=%b mem_en=%b rsp_valid=%b want 0", i, bus.grant,
                 bus.mem_en, bus.rsp_valid);
      end
      if (i == 0) begin
        checks++;
        if (bus.rsp_data !== 24'd0 || bus.mem_addr !== 10'd0 || bus.mem_table !== 2'd0 ||
            bus.max_wait !== 8'd0) begin
          failures++;
          $display("FAIL reset_values rsp_data=%h mem_addr=%h mem_table=%h max_wait=%0d want 0",
                   bus.rsp_data, bus.mem_addr, bus.mem_table, bus.max_wait);
        end
      end
    end
  endtask

  task automatic test_single();
    rom_force = 1'b1;
    rom_force_val = 24'hABCDEF;
    @(negedge clk);
    bus.req = 4'b0100;
    bus.req_table[2] = 2'd1;
    bus.req_addr[2] = 10'h155;
    #1;
    checks++;
    if (bus.grant !== 4'b0100) begin
      failures++; $display("FAIL single_grant got=%b want=0100", bus.grant);
    end
    @(negedge clk);
    bus.req = '0;
    #1;
    checks++;
    if (bus.mem_en !== 1'b1 || bus.mem_addr !== 10'h155 || bus.mem_table !== 2'd1) begin
      failures++;
      $display("FAIL single_issue mem_en=%b addr=%h table=%h want 1/155/1", bus.mem_en,
               bus.mem_addr, bus.mem_table);
    end
    @(negedge clk); #1;
    checks++;
    if (bus.rsp_valid !== 4'b0) begin
      failures++; $display("FAIL single_early_rsp got=%b want=0000", bus.rsp_valid);
    end
    @(negedge clk); #1;
    checks++;
    if (bus.rsp_valid !== 4'b0100 || bus.rsp_data !== 24'hABCDEF) begin
      failures++;
      $display("FAIL single_rsp valid=%b data=%h want 0100/abcdef", bus.rsp_valid, bus.rsp_data);
    end
    @(negedge clk); #1;
    checks++;
    if (bus.rsp_valid !== 4'b0 || bus.rsp_data !== 24'hABCDEF || bus.mem_en !== 1'b0 ||
        bus.mem_addr !== 10'h155) begin
      failures++;
      $display("FAIL single_hold valid=%b data=%h mem_en=%b addr=%h want 0000/abcdef/0/155",
               bus.rsp_valid, bus.rsp_data, bus.mem_en, bus.mem_addr);
    end
    rom_force = 1'b0;
  endtask

  task automatic test_all_four();
    owner_t want;
    int pulses = 0;
    apply_reset();
    for (int k = 0; k < P; k++) begin
      bus.req_table[k] = 2'(k);
      bus.req_addr[k]  = 10'(16 * k + 3);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus.req = (i < 8) ? 4'b1111 : 4'b0000;
      #1;
      want = (i < 8) ? owner_t'(1) << (i % P) : '0;
      checks++;
      if (bus.grant !== want) begin
        failures++; $display("FAIL all4_grant i=%0d got=%b want=%b", i, bus.grant, want);
      end
      want = (i >= 3 && i < 11) ? owner_t'(1) << ((i - 3) % P) : '0;
      checks++;
      if (bus.rsp_valid !== want) begin
        failures++; $display("FAIL all4_rsp i=%0d got=%b want=%b", i, bus.rsp_valid, want);
      end
      if (want != '0) begin
        pulses++;
        checks++;
        if (bus.rsp_data !== rom_fn(2'((i - 3) % P), 10'(16 * ((i - 3) % P) + 3))) begin
          failures++; $display("FAIL all4_data i=%0d got=%h", i, bus.rsp_data);
        end
      end
    end
    checks++;
    if (pulses != 8) begin
      failures++; $display("FAIL all4_pulses got=%0d want=8", pulses);
    end
  endtask

  task automatic test_back_to_back();
    owner_t ev;
    int rsps = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      bus.req = (i < 10) ? 4'b0010 : 4'b0000;
      bus.req_table[1] = 2'($urandom);
      bus.req_addr[1]  = 10'($urandom);
      #1;
      checks++;
      if (bus.grant !== ((i < 10) ? 4'b0010 : 4'b0000)) begin
        failures++; $display("FAIL b2b_grant i=%0d got=%b", i, bus.grant);
      end
      ev = (exp_q.size() > 0 && exp_q[0].due == cyc) ? exp_q[0].owner : '0;
      checks++;
      if (bus.rsp_valid !== ev) begin
        failures++; $display("FAIL b2b_rsp i=%0d got=%b want=%b", i, bus.rsp_valid, ev);
      end
      if (ev != '0) begin
        rsps++;
        checks++;
        if (bus.rsp_data !== exp_q[0].data) begin
          failures++;
          $display("FAIL b2b_data i=%0d got=%h want=%h", i, bus.rsp_data, exp_q[0].data);
        end
      end
    end
    checks++;
    if (rsps != 10) begin
      failures++; $display("FAIL b2b_count got=%0d want=10", rsps);
    end
  endtask

  task automatic test_random();
    owner_t eg, ev;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      bus.req = owner_t'($urandom_range(0, 15));
      for (int k = 0; k < P; k++) begin
        bus.req_table[k] = 2'($urandom);
        bus.req_addr[k]  = 10'($urandom);
      end
      #1;
      eg = model_pick(bus.req, m_ptr);
      ev = (exp_q.size() > 0 && exp_q[0].due == cyc) ? exp_q[0].owner : '0;
      checks++;
      if (bus.grant !== eg) begin
        failures++; $display("FAIL rand_grant i=%0d got=%b want=%b", i, bus.grant, eg);
      end
      checks++;
      if (bus.mem_en !== m_en || bus.mem_addr !== m_issue.addr ||
          bus.mem_table !== m_issue.table_sel) begin
        failures++;
        $display("FAIL rand_issue i=%0d en=%b addr=%h table=%h want %b/%h/%h", i, bus.mem_en,
                 bus.mem_addr, bus.mem_table, m_en, m_issue.addr, m_issue.table_sel);
      end
      checks++;
      if (bus.rsp_valid !== ev) begin
        failures++; $display("FAIL rand_rsp i=%0d got=%b want=%b", i, bus.rsp_valid, ev);
      end
      if (ev != '0) begin
        checks++;
        if (bus.rsp_data !== exp_q[0].data) begin
          failures++;
          $display("FAIL rand_data i=%0d got=%h want=%h", i, bus.rsp_data, exp_q[0].data);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    @(negedge clk);
    bus.req = 4'b1000;
    bus.req_table[3] = 2'd2;
    bus.req_addr[3] = 10'h2AA;
    #1;
    checks++;
    if (bus.grant !== 4'b1000) begin
      failures++; $display("FAIL midrst_grant3 got=%b want=1000", bus.grant);
    end
    @(negedge clk);
    bus.req = 4'b0001;
    #1;
    checks++;
    if (bus.grant !== 4'b0001) begin
      failures++; $display("FAIL midrst_grant0 got=%b want=0001", bus.grant);
    end
    // Pulse reset in the cycle before pipeline 3's response would register.
    @(negedge clk);
    bus.req = '0;
    reset_l = 1'b0;
    @(negedge clk);
    reset_l = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      checks++;
      if (bus.rsp_valid !== 4'b0) begin
        failures++; $display("FAIL midrst_stale_rsp i=%0d got=%b want=0000", i, bus.rsp_valid);
      end
    end
    @(negedge clk);
    bus.req = 4'b0011;
    #1;
    checks++;
    if (bus.grant !== 4'b0001) begin
      failures++; $display("FAIL midrst_ptr got=%b want=0001", bus.grant);
    end
    @(negedge clk);
    bus.req = '0;
  endtask

  task automatic test_stats();
    owner_t eg;
    owner_t last_g = '0;
    apply_reset();
    @(negedge clk);
    bus.req = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        @(negedge clk);
        bus.req = bus.req & ~last_g;
      end
      #1;
      eg = model_pick(bus.req, m_ptr);
      checks++;
      if (bus.grant !== eg) begin
        failures++; $display("FAIL stats_grant i=%0d got=%b want=%b", i, bus.grant, eg);
      end
      last_g = eg;
      if (i >= 4) begin
        checks++;
        if (bus.max_wait !== ExpMaxWait) begin
          failures++;
          $display("FAIL stats_max_wait i=%0d got=%0d want=%0d", i, bus.max_wait, ExpMaxWait);
        end
      end
    end
  endtask

  initial begin
    bus.req = '0;
    bus.req_table = '0;
    bus.req_addr = '0;
    test_reset();
    test_single();
    test_all_four();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    test_stats();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
